mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares one external cartridge memory port between three requesters:
- chr: PPU-side CHR fetch/write.
- prg: CPU-side PRG fetch.
- host: MCU loader and debug access.

The block sits between the mapper address outputs and the memory controller. It serialises requests, applies fixed priority with a host anti-starvation guard, and enforces a completion timeout.

Parameters:
ADDR_BITS, 22, width of all address buses
DATA_BITS, 8, width of all data buses
HOST_MAX_WAIT, 8, number of consecutive non-host grants allowed while host is pending before host is forced
TIMEOUT, 255, cycles to wait for mem_ack before the transaction is aborted (legal range 1..255)

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
chr_req  in  1  CHR request, level, held until chr_ack
chr_we  in  1  CHR write enable
chr_addr  in  ADDR_BITS  CHR address
chr_wdata  in  DATA_BITS  CHR write data
chr_ack  out  1  one-cycle completion pulse
prg_req / prg_we / prg_addr / prg_wdata / prg_ack  same widths and meaning as chr_*, PRG requester
host_req / host_we / host_addr / host_wdata / host_ack  same widths and meaning as chr_*, host requester
rdata  out  DATA_BITS  read data, valid in the cycle any *_ack is high
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_BITS  memory address
mem_wdata  out  DATA_BITS  memory write data
mem_ack  in  1  one-cycle completion pulse from the memory controller
mem_rdata  in  DATA_BITS  memory read data, valid with mem_ack
timeout_err  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, all *_ack, rdata, timeout_err.
  - Starvation counter 0, timeout counter 0, ack mask cleared.
  - Any in-flight memory transaction is abandoned; a mem_ack arriving after reset is ignored.
- States: IDLE, BUSY.
- IDLE:
  - Each cycle, evaluate the eligible requests. A requester is eligible when its req is high and it is not masked.
  - Mask: the requester acked in the previous cycle is masked for exactly one cycle. This covers the req-drop latency and prevents a double issue.
  - Priority: host if starve_cnt == HOST_MAX_WAIT and host is eligible; otherwise chr > prg > host.
  - On a grant at edge N:
    - Register the winner's we, addr and wdata onto the mem_* outputs.
    - mem_req goes high after edge N.
    - Go to BUSY and load the timeout counter with 0.
  - No eligible request: stay in IDLE, mem_req low.
- BUSY:
  - mem_req and mem_* outputs are held stable.
  - mem_ack == 1:
    - Next cycle: the winner's *_ack = 1 for one cycle and rdata = registered mem_rdata (rdata also updated on writes).
    - mem_req drops.
    - Return to IDLE.
    - The acked requester is masked in that IDLE cycle.
    - The ack cycle and the next grant may coincide: ack at cycle M, new mem_req high from M+1.
  - mem_ack == 0: increment the timeout counter.
    - When the count reaches TIMEOUT without mem_ack: drop mem_req, pulse timeout_err, pulse the winner's *_ack (rdata = 0), return to IDLE. The requester is never left hung.
- Latency: minimum request-to-ack is 3 cycles when mem_ack arrives in the first BUSY cycle (req sampled at edge N, mem_req high after N, mem_ack sampled at N+1, ack high after N+2).
- Starvation counter, updated on each grant:
  - Host grant: reset to 0.
  - chr/prg grant while host_req is high: increment, saturating at HOST_MAX_WAIT.
  - Grant while host_req is low: cleared to 0.
- Simultaneous events:
  - Request changes while BUSY are ignored until IDLE.
  - A requester deasserting req while BUSY still receives its ack (no cancel).
  - mem_ack in IDLE is ignored.
- Invariants:
  - At most one *_ack high per cycle.
  - mem_* outputs change only on a grant.

Decomposition:
- Package mem_arb_pkg:
  - requester_t enum {REQ_NONE, REQ_CHR, REQ_PRG, REQ_HOST}.
  - state_t enum {IDLE, BUSY}.
  - Timeout counter width localparam = 8 bits (covers TIMEOUT up to 255).
- One sub-module, mem_arb_pick: combinational priority select. Inputs: eligible vector, force_host. Output: requester_t winner.

Test Plan:
- Single read: prg_req=1, addr 0x004000; memory acks 1 cycle after mem_req -> mem_addr=0x004000, mem_we=0, prg_ack pulses 3 cycles after req, rdata=0xA5 matches mem_rdata.
- Contention: chr_req and prg_req raised in the same cycle -> chr granted first, prg granted in the chr_ack cycle; exactly one ack per requester, no duplicate mem_req for chr.
- Starvation: chr and prg requesting back-to-back continuously, host_req held -> host granted on the 9th grant (HOST_MAX_WAIT=8); starve_cnt returns to 0.
- Timeout: host write 0x3C to 0x1FFFFF, mem_ack never asserted -> after 255 BUSY cycles mem_req=0, timeout_err pulse, host_ack pulse, rdata=0.
- Reset mid-BUSY: assert reset while mem_req=1 -> mem_req=0 immediately (asynchronous); a later mem_ack produces no *_ack.
- Write passthrough: chr_we=1, chr_addr 0x000123, chr_wdata 0x7E -> mem_we=1, mem_addr=0x000123, mem_wdata=0x7E stable until mem_ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cartridge memory arbiter.
//   requester_t : identifies which requester owns the memory port
//   state_t     : arbiter FSM states
//   TMO_W       : width of the completion-timeout counter (TIMEOUT <= 255)
//   req_onehot  : maps a requester to its bit in {host, prg, chr} vectors
package mem_arb_pkg;

  typedef enum logic [1:0] {REQ_NONE, REQ_CHR, REQ_PRG, REQ_HOST} requester_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned TMO_W = 8;

  function automatic logic [2:0] req_onehot(input requester_t r);
    case (r)
      REQ_CHR:  return 3'b001;
      REQ_PRG:  return 3'b010;
      REQ_HOST: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: three requester ports (chr, prg, host) and the
// single downstream memory-controller port.
//   slave  : arbiter side (takes requests, drives acks and mem_*)
//   master : environment side (requesters + memory controller)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_BITS = 22,
  parameter int unsigned DATA_BITS = 8
);

  logic                 chr_req, chr_we, chr_ack;
  logic [ADDR_BITS-1:0] chr_addr;
  logic [DATA_BITS-1:0] chr_wdata;

  logic                 prg_req, prg_we, prg_ack;
  logic [ADDR_BITS-1:0] prg_addr;
  logic [DATA_BITS-1:0] prg_wdata;

  logic                 host_req, host_we, host_ack;
  logic [ADDR_BITS-1:0] host_addr;
  logic [DATA_BITS-1:0] host_wdata;

  logic [DATA_BITS-1:0] rdata;

  logic                 mem_req, mem_we, mem_ack;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata, mem_rdata;

  logic                 timeout_err;

  modport slave (
    input  chr_req, chr_we, chr_addr, chr_wdata,
    input  prg_req, prg_we, prg_addr, prg_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_ack, mem_rdata,
    output chr_ack, prg_ack, host_ack, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output chr_req, chr_we, chr_addr, chr_wdata,
    output prg_req, prg_we, prg_addr, prg_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_ack, mem_rdata,
    input  chr_ack, prg_ack, host_ack, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational priority select for mem_arbiter.
//   elig_i       : eligible requesters, bit0 chr, bit1 prg, bit2 host
//   force_host_i : starvation guard tripped, host wins if eligible
//   winner_o     : selected requester, REQ_NONE when nothing eligible
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] elig_i,
  input  logic       force_host_i,
  output requester_t winner_o
);

  always_comb begin
    winner_o = REQ_NONE;
    if (force_host_i && elig_i[2]) winner_o = REQ_HOST;
    else if (elig_i[0])            winner_o = REQ_CHR;
    else if (elig_i[1])            winner_o = REQ_PRG;
    else if (elig_i[2])            winner_o = REQ_HOST;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one cartridge memory port between chr, prg and host requesters.
// Fixed priority chr > prg > host, with host forced after HOST_MAX_WAIT
// consecutive non-host grants while host waits. A transaction without
// mem_ack for TIMEOUT cycles is aborted with timeout_err and an ack.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : requester and memory signals (mem_arbiter_if.slave)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 22,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned HOST_MAX_WAIT = 8,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned STARVE_W = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;

  state_t               state_q, state_d;
  requester_t           owner_q, owner_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [2:0]           ack_q, ack_d;
  logic                 terr_q, terr_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 pend_q, pend_d;

  logic [2:0]           elig;
  logic                 force_host;
  requester_t           winner;

  // The requester acked this cycle is the one masked for this IDLE cycle.
  assign elig       = {bus.host_req, bus.prg_req, bus.chr_req} & ~ack_q;
  assign force_host = (starve_q == STARVE_W'(HOST_MAX_WAIT));

  mem_arb_pick u_pick (
    .elig_i       (elig),
    .force_host_i (force_host),
    .winner_o     (winner)
  );

  // mem_ack drops mem_req and captures rdata at once; the ack is issued one
  // cycle later (pend_q) so it coincides with the return to IDLE and the mask.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    ack_d       = '0;
    terr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != REQ_NONE) begin
          case (winner)
            REQ_CHR: begin
              mem_we_d    = bus.chr_we;
              mem_addr_d  = bus.chr_addr;
              mem_wdata_d = bus.chr_wdata;
            end
            REQ_PRG: begin
              mem_we_d    = bus.prg_we;
              mem_addr_d  = bus.prg_addr;
              mem_wdata_d = bus.prg_wdata;
            end
            default: begin
              mem_we_d    = bus.host_we;
              mem_addr_d  = bus.host_addr;
              mem_wdata_d = bus.host_wdata;
            end
          endcase
          mem_req_d = 1'b1;
          owner_d   = winner;
          tmo_d     = '0;
          pend_d    = 1'b0;
          state_d   = BUSY;
          if (winner == REQ_HOST)  starve_d = '0;
          else if (bus.host_req)   starve_d = force_host ? starve_q : starve_q + STARVE_W'(1);
          else                     starve_d = '0;
        end
      end
      BUSY: begin
        if (pend_q) begin
          ack_d   = req_onehot(owner_q);
          pend_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
          pend_d    = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          ack_d     = req_onehot(owner_q);
          terr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      terr_q      <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      terr_q      <= terr_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.chr_ack     = ack_q[0];
  assign bus.prg_ack     = ack_q[1];
  assign bus.host_ack    = ack_q[2];
  assign bus.timeout_err = terr_q;

endmodule
